// File: rtl/writeback_regfile_pkg.sv
// Shared widths and register indices for the S2/S3 pipeline registers and the writeback regfile.
package writeback_regfile_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int REG_ZERO      = 0;

endpackage

// File: rtl/writeback_regfile_bypass_mux.sv
// Per-read-port select between stored data, in-flight write data and the hardwired zero register.
module regfile_bypass_mux
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0] rd_sel,
  input  logic                  wr_commit,
  input  logic [ADDR_WIDTH-1:0] wr_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_stored,
  output logic [DATA_WIDTH-1:0] rd_data
);

  always_comb begin
    rd_data = rd_stored;
    if ((BYPASS != 0) && wr_commit && (rd_sel == wr_sel)) begin
      rd_data = wr_data;
    end
    // The zero register overrides bypass so r0 can never appear non-zero.
    if ((ZERO_REG != 0) && (rd_sel == ADDR_WIDTH'(REG_ZERO))) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// S3 writeback register file: storage, commit qualification and write counter.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  S3_WriteEnable,
  input  logic [ADDR_WIDTH-1:0] S3_WriteSelect,
  input  logic [DATA_WIDTH-1:0] S3_ALUOp_Out,
  input  logic [ADDR_WIDTH-1:0] ReadSelect1,
  input  logic [ADDR_WIDTH-1:0] ReadSelect2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic [15:0]           WriteCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [15:0]           wr_cnt_q;
  logic [15:0]           wr_cnt_d;
  logic                  wr_zero;
  logic                  wr_commit;

  // Gating with rst keeps bypass off while reset is held.
  assign wr_zero   = (ZERO_REG != 0) && (S3_WriteSelect == ADDR_WIDTH'(REG_ZERO));
  assign wr_commit = rst && S3_WriteEnable && !wr_zero;

  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (wr_commit) begin
      regs_d[S3_WriteSelect] = S3_ALUOp_Out;
      wr_cnt_d               = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q   <= '{default: '0};
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  regfile_bypass_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG),
    .BYPASS    (BYPASS)
  ) u_mux_rd1 (
    .rd_sel   (ReadSelect1),
    .wr_commit(wr_commit),
    .wr_sel   (S3_WriteSelect),
    .wr_data  (S3_ALUOp_Out),
    .rd_stored(regs_q[ReadSelect1]),
    .rd_data  (ReadData1)
  );

  regfile_bypass_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG),
    .BYPASS    (BYPASS)
  ) u_mux_rd2 (
    .rd_sel   (ReadSelect2),
    .wr_commit(wr_commit),
    .wr_sel   (S3_WriteSelect),
    .wr_data  (S3_ALUOp_Out),
    .rd_stored(regs_q[ReadSelect2]),
    .rd_data  (ReadData2)
  );

  assign WriteCount = wr_cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: one bypassing instance and one BYPASS=0 instance on shared stimulus.
module tb_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  ws;
  logic [31:0] wd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic [15:0] wc, wc_nb;

  int n_cmp = 0;
  int n_err = 0;

  writeback_regfile dut (
    .clk(clk), .rst(rst_n), .S3_WriteEnable(we), .S3_WriteSelect(ws), .S3_ALUOp_Out(wd),
    .ReadSelect1(rs1), .ReadSelect2(rs2), .ReadData1(rd1), .ReadData2(rd2), .WriteCount(wc)
  );

  writeback_regfile #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst_n), .S3_WriteEnable(we), .S3_WriteSelect(ws), .S3_ALUOp_Out(wd),
    .ReadSelect1(rs1), .ReadSelect2(rs2), .ReadData1(rd1_nb), .ReadData2(rd2_nb), .WriteCount(wc_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] sel, input logic [31:0] data);
    we = 1'b1; ws = sel; wd = data;
    tick();
    we = 1'b0; ws = 'x; wd = 'x;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; ws = '0; wd = '0; rs1 = '0; rs2 = '0;

    // Writes while reset is held must be discarded, and reads stay 0 even with bypass.
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; ws = 5'(i); wd = 32'hA5A50000 + i; rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      chk("rst_rd1", rd1, 32'h0);
      chk("rst_rd2", rd2, 32'h0);
      tick();
    end
    chk("rst_wc", {16'h0, wc}, 32'h0);
    rst_n = 1'b1; we = 1'b0;
    #1;

    write(5'd5, 32'hDEADBEEF);
    rs1 = 5'd5; #1;
    chk("wr_r5", rd1, 32'hDEADBEEF);
    chk("wr_wc1", {16'h0, wc}, 32'h1);

    we = 1'b1; ws = 5'd7; wd = 32'h12345678; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    chk("byp_rd1", rd1, 32'h12345678);
    chk("byp_rd2", rd2, 32'h12345678);
    chk("nobyp_rd1", rd1_nb, 32'h0);
    chk("nobyp_rd2", rd2_nb, 32'h0);
    tick();
    we = 1'b0; #1;
    chk("nobyp_after", rd1_nb, 32'h12345678);
    chk("byp_wc2", {16'h0, wc}, 32'h2);

    we = 1'b1; ws = 5'd0; wd = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    chk("zero_byp", rd1, 32'h0);
    tick();
    we = 1'b0; #1;
    chk("zero_rd", rd1, 32'h0);
    chk("zero_rd_nb", rd2_nb, 32'h0);
    chk("zero_wc", {16'h0, wc}, 32'h2);

    write(5'd9, 32'h1);
    write(5'd9, 32'h2);
    rs1 = 5'd9; #1;
    chk("b2b_last", rd1, 32'h2);
    chk("b2b_wc", {16'h0, wc}, 32'h4);

    for (int i = 1; i < 32; i++) write(5'(i), 32'(i));
    rs1 = 5'd1; rs2 = 5'd31; #1;
    chk("load_r1", rd1, 32'h1);
    chk("load_r31", rd2, 32'h1F);
    chk("load_wc", {16'h0, wc}, 32'd35);

    // Reset pulsed between edges with a write pending; the edge inside reset must not commit.
    we = 1'b1; ws = 5'd4; wd = 32'h00000BAD; rs1 = 5'd4; rs2 = 5'd31;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rd1", rd1, 32'h0);
    chk("arst_rd2", rd2, 32'h0);
    chk("arst_wc", {16'h0, wc}, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1; we = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); #1;
      chk("arst_clear", rd1, 32'h0);
    end
    chk("arst_nocommit_wc", {16'h0, wc}, 32'h0);

    we = 1'b1; ws = 5'd2;
    for (int i = 0; i < 65535; i++) begin
      wd = 32'(i);
      tick();
    end
    chk("wrap_ffff", {16'h0, wc}, 32'h0000FFFF);
    wd = 32'h0000FFFF;
    tick();
    we = 1'b0; rs1 = 5'd2; #1;
    chk("wrap_zero", {16'h0, wc}, 32'h0);
    chk("wrap_nb_zero", {16'h0, wc_nb}, 32'h0);
    chk("wrap_r2", rd1, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
